// File: rtl/quad_input_filter_if.sv
// Signal bundle for the quadrature input filter: raw encoder inputs in,
// debounced levels, strobes and error status out.
interface quad_input_filter_if #(
  parameter int unsigned ERR_W = 8
);
  logic             quadA_in;
  logic             quadB_in;
  logic             index_in;
  logic             clr_err;
  logic             quadA_f;
  logic             quadB_f;
  logic             index_f;
  logic             index_pulse;
  logic             ready;
  logic             err_pulse;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output quadA_in, quadB_in, index_in, clr_err,
    input  quadA_f, quadB_f, index_f, index_pulse, ready, err_pulse, err_sticky, err_cnt
  );

  modport slave (
    input  quadA_in, quadB_in, index_in, clr_err,
    output quadA_f, quadB_f, index_f, index_pulse, ready, err_pulse, err_sticky, err_cnt
  );
endinterface

// File: rtl/quad_input_filter.sv
// Synchronizes and debounces quadrature A/B/index inputs, flags A/B changing together
// as an illegal transition and counts such events with a saturating counter.
module quad_input_filter #(
  parameter int unsigned FILT_CYCLES = 8,
  parameter int unsigned ERR_W       = 8
) (
  input logic                clk,
  input logic                rst,
  quad_input_filter_if.slave bus
);
  localparam logic [0:0]       StInit  = 1'b0;
  localparam logic [0:0]       StRun   = 1'b1;
  localparam logic [7:0]       LastCnt = 8'(FILT_CYCLES - 1);
  localparam logic [ERR_W-1:0] ErrMax  = '1;

  // Channel bit order throughout: {A, B, index}
  logic [2:0]       raw;
  logic [0:0]       state_q, state_d;
  logic [2:0]       s1_q, s2_q, prev_q;
  logic [2:0]       filt_q, filt_d;
  logic [2:0][7:0]  cnt_q, cnt_d;
  logic [7:0]       prime_q, prime_d;
  logic [2:0]       mis, upd;
  logic             prime_done, illegal, idx_rise;
  logic             index_pulse_q, err_pulse_q;
  logic             err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  assign raw = {bus.quadA_in, bus.quadB_in, bus.index_in};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mis[i]   = s2_q[i] != filt_q[i];
      upd[i]   = (state_q == StRun) && mis[i] && (cnt_q[i] == LastCnt);
      cnt_d[i] = ((state_q == StRun) && mis[i] && !upd[i]) ? cnt_q[i] + 8'd1 : 8'd0;
    end
  end

  // Priming requires the whole s2 vector to sit still for FILT_CYCLES edges.
  assign prime_done = (state_q == StInit) && (s2_q == prev_q) && (prime_q == LastCnt);
  assign illegal    = upd[2] & upd[1];
  assign idx_rise   = upd[0] & s2_q[0];

  always_comb begin
    prime_d = 8'd0;
    if ((state_q == StInit) && (s2_q == prev_q) && !prime_done) begin
      prime_d = prime_q + 8'd1;
    end
    state_d = prime_done ? StRun : state_q;
    filt_d  = prime_done ? s2_q : ((filt_q & ~upd) | (s2_q & upd));
  end

  // An illegal transition outranks a coincident clear, so it restarts the count at one.
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (illegal) begin
      err_sticky_d = 1'b1;
      if (bus.clr_err) begin
        err_cnt_d = ERR_W'(1);
      end else if (err_cnt_q != ErrMax) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end else if (bus.clr_err) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StInit;
      s1_q          <= '0;
      s2_q          <= '0;
      prev_q        <= '0;
      filt_q        <= '0;
      cnt_q         <= '0;
      prime_q       <= '0;
      index_pulse_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      s1_q          <= raw;
      s2_q          <= s1_q;
      prev_q        <= s2_q;
      filt_q        <= filt_d;
      cnt_q         <= cnt_d;
      prime_q       <= prime_d;
      index_pulse_q <= idx_rise;
      err_pulse_q   <= illegal;
      err_sticky_q  <= err_sticky_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign bus.quadA_f     = filt_q[2];
  assign bus.quadB_f     = filt_q[1];
  assign bus.index_f     = filt_q[0];
  assign bus.index_pulse = index_pulse_q;
  assign bus.ready       = (state_q == StRun);
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench for quad_input_filter at FILT_CYCLES=8, ERR_W=8.
module tb_quad_input_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   idx_pulses = 0;
  int   err_pulses = 0;
  logic exp_a = 1'b0;
  logic exp_b = 1'b0;

  quad_input_filter_if #(.ERR_W(8)) bus ();

  quad_input_filter #(.FILT_CYCLES(8), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      idx_pulses += int'(bus.index_pulse);
      err_pulses += int'(bus.err_pulse);
    end
  endtask

  // Inputs held stable from release: s2 settles after 2 edges, then 8 quiet edges prime.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    check(tag, n, 11);
  endtask

  // Apply A/B levels; filtered outputs must change exactly 10 edges later.
  task automatic phase(input logic a, input logic b, input string tag);
    bus.quadA_in = a;
    bus.quadB_in = b;
    step(9);
    check({tag, "_hold_a"}, bus.quadA_f, exp_a);
    check({tag, "_hold_b"}, bus.quadB_f, exp_b);
    step(1);
    exp_a = a;
    exp_b = b;
    check({tag, "_new_a"}, bus.quadA_f, exp_a);
    check({tag, "_new_b"}, bus.quadB_f, exp_b);
    step(10);
  endtask

  initial begin
    bus.quadA_in = 1'b1;
    bus.quadB_in = 1'b0;
    bus.index_in = 1'b0;
    bus.clr_err  = 1'b0;
    step(2);
    check("rst_ready", bus.ready, 0);
    check("rst_qa", bus.quadA_f, 0);
    check("rst_errcnt", bus.err_cnt, 0);

    // Prime with A=1 B=0 index=0
    rst = 1'b0;
    idx_pulses = 0;
    err_pulses = 0;
    wait_ready("prime_edges");
    check("prime_qa", bus.quadA_f, 1);
    check("prime_qb", bus.quadB_f, 0);
    check("prime_idx", bus.index_f, 0);
    check("prime_errcnt", bus.err_cnt, 0);
    check("prime_no_pulses", idx_pulses + err_pulses, 0);
    exp_a = 1'b1;
    exp_b = 1'b0;

    phase(1'b0, 1'b0, "a_fall");

    // 7-cycle glitch is rejected
    bus.quadA_in = 1'b1;
    step(7);
    bus.quadA_in = 1'b0;
    step(9);
    check("glitch7_qa", bus.quadA_f, 0);
    step(11);
    check("glitch7_qa_late", bus.quadA_f, 0);

    // 8-cycle pulse is accepted 10 edges after being driven
    bus.quadA_in = 1'b1;
    step(8);
    bus.quadA_in = 1'b0;
    step(1);
    check("pulse8_qa_e9", bus.quadA_f, 0);
    step(1);
    check("pulse8_qa_e10", bus.quadA_f, 1);
    step(20);
    check("pulse8_qa_end", bus.quadA_f, 0);

    err_pulses = 0;
    phase(1'b1, 1'b0, "gray10");
    phase(1'b1, 1'b1, "gray11");
    phase(1'b0, 1'b1, "gray01");
    phase(1'b0, 1'b0, "gray00");
    check("gray_errcnt", bus.err_cnt, 0);
    check("gray_sticky", bus.err_sticky, 0);
    check("gray_errpulses", err_pulses, 0);

    // Index: one pulse on rise, none on fall
    bus.index_in = 1'b1;
    idx_pulses = 0;
    step(20);
    check("idx_rise_pulses", idx_pulses, 1);
    check("idx_high", bus.index_f, 1);
    bus.index_in = 1'b0;
    idx_pulses = 0;
    step(20);
    check("idx_fall_pulses", idx_pulses, 0);
    check("idx_low", bus.index_f, 0);
    check("idx_no_err", bus.err_cnt, 0);

    // Illegal: A and B change together
    err_pulses = 0;
    bus.quadA_in = 1'b1;
    bus.quadB_in = 1'b1;
    step(9);
    check("ill_pre_pulse", bus.err_pulse, 0);
    step(1);
    check("ill_qa", bus.quadA_f, 1);
    check("ill_qb", bus.quadB_f, 1);
    check("ill_pulse", bus.err_pulse, 1);
    check("ill_cnt", bus.err_cnt, 1);
    check("ill_sticky", bus.err_sticky, 1);
    step(10);
    check("ill_pulse_count", err_pulses, 1);

    bus.clr_err = 1'b1;
    step(1);
    bus.clr_err = 1'b0;
    check("clr_cnt", bus.err_cnt, 0);
    check("clr_sticky", bus.err_sticky, 0);

    // Clear coincident with an accepted illegal transition: error wins
    bus.quadA_in = 1'b0;
    bus.quadB_in = 1'b0;
    step(9);
    bus.clr_err = 1'b1;
    step(1);
    bus.clr_err = 1'b0;
    check("coinc_cnt", bus.err_cnt, 1);
    check("coinc_sticky", bus.err_sticky, 1);
    check("coinc_pulse", bus.err_pulse, 1);
    step(10);

    // Saturation: 300 more illegal transitions on top of count 1
    for (int r = 0; r < 300; r++) begin
      bus.quadA_in = (r % 2 == 0);
      bus.quadB_in = (r % 2 == 0);
      step(20);
      if (r == 99) check("sat_cnt_101", bus.err_cnt, 101);
    end
    check("sat_cnt", bus.err_cnt, 255);
    check("sat_ready", bus.ready, 1);

    // Mid-phase reset clears everything immediately
    bus.quadA_in = 1'b1;
    bus.index_in = 1'b1;
    step(5);
    rst = 1'b1;
    #1;
    check("mrst_ready", bus.ready, 0);
    check("mrst_cnt", bus.err_cnt, 0);
    check("mrst_sticky", bus.err_sticky, 0);
    check("mrst_outs", {bus.quadA_f, bus.quadB_f, bus.index_f, bus.index_pulse, bus.err_pulse}, 0);
    step(3);
    rst = 1'b0;
    idx_pulses = 0;
    err_pulses = 0;
    wait_ready("reprime_edges");
    check("reprime_qa", bus.quadA_f, 1);
    check("reprime_qb", bus.quadB_f, 0);
    check("reprime_idx", bus.index_f, 1);
    check("reprime_no_pulses", idx_pulses + err_pulses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/quad_input_filter.md
QUAD_INPUT_FILTER -- requirements
Module: quad_input_filter

Interface
REQ-001 Parameter FILT_CYCLES, default 8: consecutive stable cycles (range 2..255) needed to accept an input level.
REQ-002 Parameter ERR_W, default 8: width of the illegal-transition counter.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 quadA_in  input  1  raw encoder channel A, asynchronous to clk.
REQ-006 quadB_in  input  1  raw encoder channel B, asynchronous to clk.
REQ-007 index_in  input  1  raw encoder index, asynchronous to clk.
REQ-008 clr_err  input  1  synchronous clear of err_cnt and err_sticky.
REQ-009 quadA_f  output  1  filtered A; feeds the quadrature decoder quadA input.
REQ-010 quadB_f  output  1  filtered B; feeds the quadrature decoder quadB input.
REQ-011 index_f  output  1  filtered index level.
REQ-012 index_pulse  output  1  one-cycle strobe on each index_f 0->1 transition.
REQ-013 ready  output  1  high once the filter has primed (RUN state).
REQ-014 err_pulse  output  1  one-cycle strobe per illegal A/B transition.
REQ-015 err_sticky  output  1  set by any illegal transition; held until clr_err.
REQ-016 err_cnt  output  ERR_W  saturating count of illegal transitions.

Function
REQ-017 Each raw input SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-018 FSM states INIT and RUN; reset enters INIT.
REQ-019 INIT: 8-bit prime counter clears whenever the {A,B,index} s2 vector differs from its previous-cycle value, else increments.
REQ-020 INIT: on the edge the prime counter reaches FILT_CYCLES, quadA_f/quadB_f/index_f SHALL load the s2 values, state -> RUN, ready = 1; no err_pulse or index_pulse for this load.
REQ-021 RUN: per channel, an 8-bit filter counter increments on each edge where s2 differs from the channel's filtered output, clears on any edge where they match.
REQ-022 RUN: when a channel's mismatch count would reach FILT_CYCLES, the filtered output SHALL take the s2 value on that edge and its counter SHALL clear.
REQ-023 Latency: a level held stable appears on the filtered output FILT_CYCLES+1 edges after the edge that first samples it into s1 (9 edges at default).
REQ-024 Any excursion held fewer than FILT_CYCLES s2 cycles SHALL be rejected, with no output change.
REQ-025 Illegal transition: quadA_f and quadB_f both updating on the same edge in RUN; err_pulse = 1 for the following cycle.
REQ-026 On an illegal transition err_sticky = 1 and err_cnt increments, holding at 2^ERR_W-1 (no wrap).
REQ-027 clr_err SHALL clear err_cnt to 0 and err_sticky to 0 on the next edge.
REQ-028 clr_err coincident with an illegal transition: error wins, giving err_cnt = 1 and err_sticky = 1.
REQ-029 index_pulse = 1 for exactly one cycle after each edge on which index_f goes 0->1 in RUN; never on 1->0.
REQ-030 A and B filtering is independent; the index update never generates an error.

Reset
REQ-031 rst asserted SHALL immediately force all outputs, synchronizer flops, counters and the filtered levels to 0, and state to INIT.
REQ-032 rst asserted mid-operation SHALL abort RUN; re-priming per REQ-019/020 SHALL be required after release.

Verification
REQ-033 Release rst with A=1, B=0, index=0 held stable -> ready, quadA_f=1, quadB_f=0 load together; err_cnt=0; no pulses.
REQ-034 In RUN, 7-cycle high pulse on quadA_in -> quadA_f stays 0; 8-cycle pulse -> quadA_f rises 9 edges after the first s1 sample.
REQ-035 Gray sequence 00-10-11-01-00, 20 cycles per phase -> filtered outputs follow with 9-cycle delay; err_cnt=0, err_sticky=0.
REQ-036 A and B toggled on the same clk edge, held 20 cycles -> one err_pulse, err_cnt=1, err_sticky=1; 300 repeats -> err_cnt saturates at 255.
REQ-037 clr_err asserted on the edge an illegal transition is accepted -> err_cnt=1, err_sticky=1; clr_err alone -> both 0.
REQ-038 index_in high for 20 cycles -> exactly one index_pulse; rst asserted mid-phase -> all outputs 0 immediately, ready=0 until re-primed.
